alu_issue_queue: RTL and testbench

Command buffer and sequencer that sits directly upstream of the 32-bit combinational ALU. It accepts operation commands over a valid/ready handshake and buffers them in a small FIFO. It drives one command at a time onto the ALU operand/opcode pins and holds them stable for a settle window. It then captures the ALU result and flags into a response register offered downstream over valid/ready. Illegal opcodes and divide-by-zero are trapped here and never reach the ALU.

---
 rtl/alu_issue_queue.sv | 216 +++++++++++++++++++++
 tb/tb_alu_issue_queue.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_queue.sv
// Command FIFO and sequencer in front of a combinational 32-bit ALU: buffers commands,
// drives one at a time onto the ALU pins, traps illegal/div-by-zero, returns responses.
module alu_issue_queue #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned TAG_W  = 4,
  parameter int unsigned SETTLE = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [15:0]              cmd_opcode,
  input  logic [31:0]              cmd_a,
  input  logic [31:0]              cmd_b,
  input  logic                     cmd_cin,
  input  logic [TAG_W-1:0]         cmd_tag,
  output logic [15:0]              alu_opcode,
  output logic [31:0]              alu_input1,
  output logic [31:0]              alu_input2,
  output logic                     alu_cin,
  input  logic [31:0]              alu_result,
  input  logic [31:0]              alu_remainder,
  input  logic                     alu_overflow,
  input  logic                     alu_zero,
  input  logic                     alu_sign,
  input  logic                     alu_carry,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [31:0]              rsp_result,
  output logic [31:0]              rsp_remainder,
  output logic [3:0]               rsp_flags,
  output logic                     rsp_err,
  output logic [TAG_W-1:0]         rsp_tag,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [15:0] OP_DIV = 16'd2;
  localparam logic [15:0] OP_MAX = 16'd13;

  typedef struct packed {
    logic [15:0]      opcode;
    logic [31:0]      a;
    logic [31:0]      b;
    logic             cin;
    logic [TAG_W-1:0] tag;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, DRIVE, HOLD} state_t;

  state_t           state_q, state_d;
  cmd_t             mem [DEPTH];
  cmd_t             cmd_in, head;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             full, empty, push, pop;
  logic             head_illegal, head_div0, head_trap;

  logic [SET_W-1:0] settle_q, settle_d;
  logic [TAG_W-1:0] cur_tag_q, cur_tag_d;
  logic [15:0]      alu_opcode_d;
  logic [31:0]      alu_input1_d, alu_input2_d;
  logic             alu_cin_d;
  logic             rsp_valid_d, rsp_err_d;
  logic [31:0]      rsp_result_d, rsp_remainder_d;
  logic [3:0]       rsp_flags_d;
  logic [TAG_W-1:0] rsp_tag_d;

  assign cmd_in    = {cmd_opcode, cmd_a, cmd_b, cmd_cin, cmd_tag};
  assign full      = (count == CNT_W'(DEPTH));
  assign empty     = (count == '0);
  assign cmd_ready = !full && !reset;
  assign push      = cmd_valid && cmd_ready;
  assign head      = mem[rd_ptr];

  assign head_illegal = (head.opcode > OP_MAX);
  assign head_div0    = (head.opcode == OP_DIV) && (head.b == '0);
  assign head_trap    = head_illegal || head_div0;

  // FIFO storage; pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= cmd_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state and pop decision; HOLD issues the next command on the handshake edge
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = head_trap ? HOLD : DRIVE;
        end
      end
      DRIVE: begin
        if (settle_q == '0) state_d = HOLD;
      end
      HOLD: begin
        if (rsp_ready) begin
          if (!empty) begin
            pop     = 1'b1;
            state_d = head_trap ? HOLD : DRIVE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath register next values
  always_comb begin
    settle_d        = settle_q;
    cur_tag_d       = cur_tag_q;
    alu_opcode_d    = alu_opcode;
    alu_input1_d    = alu_input1;
    alu_input2_d    = alu_input2;
    alu_cin_d       = alu_cin;
    rsp_valid_d     = rsp_valid;
    rsp_result_d    = rsp_result;
    rsp_remainder_d = rsp_remainder;
    rsp_flags_d     = rsp_flags;
    rsp_err_d       = rsp_err;
    rsp_tag_d       = rsp_tag;

    if (state_q == HOLD && rsp_ready) rsp_valid_d = 1'b0;

    if (state_q == DRIVE) begin
      if (settle_q == '0) begin
        rsp_valid_d     = 1'b1;
        rsp_result_d    = alu_result;
        rsp_remainder_d = (alu_opcode == OP_DIV) ? alu_remainder : 32'd0;
        rsp_flags_d     = {alu_overflow, alu_zero, alu_sign, alu_carry};
        rsp_err_d       = 1'b0;
        rsp_tag_d       = cur_tag_q;
      end else begin
        settle_d = settle_q - SET_W'(1);
      end
    end

    // Trapped commands answer immediately and leave the ALU pins untouched
    if (pop) begin
      if (head_trap) begin
        rsp_valid_d     = 1'b1;
        rsp_result_d    = head_illegal ? 32'd0 : 32'hFFFF_FFFF;
        rsp_remainder_d = head_illegal ? 32'd0 : head.a;
        rsp_flags_d     = 4'd0;
        rsp_err_d       = 1'b1;
        rsp_tag_d       = head.tag;
      end else begin
        alu_opcode_d = head.opcode;
        alu_input1_d = head.a;
        alu_input2_d = head.b;
        alu_cin_d    = head.cin;
        cur_tag_d    = head.tag;
        settle_d     = SET_W'(SETTLE - 1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      settle_q      <= '0;
      cur_tag_q     <= '0;
      alu_opcode    <= '0;
      alu_input1    <= '0;
      alu_input2    <= '0;
      alu_cin       <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_result    <= '0;
      rsp_remainder <= '0;
      rsp_flags     <= '0;
      rsp_err       <= 1'b0;
      rsp_tag       <= '0;
    end else begin
      settle_q      <= settle_d;
      cur_tag_q     <= cur_tag_d;
      alu_opcode    <= alu_opcode_d;
      alu_input1    <= alu_input1_d;
      alu_input2    <= alu_input2_d;
      alu_cin       <= alu_cin_d;
      rsp_valid     <= rsp_valid_d;
      rsp_result    <= rsp_result_d;
      rsp_remainder <= rsp_remainder_d;
      rsp_flags     <= rsp_flags_d;
      rsp_err       <= rsp_err_d;
      rsp_tag       <= rsp_tag_d;
    end
  end

endmodule

// File: tb/tb_alu_issue_queue.sv
// Bench for alu_issue_queue: attached ALU model, directed timing cases, and a
// randomized run scored against a queue of predicted responses.
module tb_alu_issue_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready;
  logic [15:0] cmd_opcode;
  logic [31:0] cmd_a, cmd_b;
  logic        cmd_cin;
  logic [3:0]  cmd_tag;
  logic [15:0] alu_opcode;
  logic [31:0] alu_input1, alu_input2;
  logic        alu_cin;
  logic [31:0] alu_result, alu_remainder;
  logic        alu_overflow, alu_zero, alu_sign, alu_carry;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_result, rsp_remainder;
  logic [3:0]  rsp_flags;
  logic        rsp_err;
  logic [3:0]  rsp_tag;
  logic [2:0]  count;

  alu_issue_queue #(.DEPTH(4), .TAG_W(4), .SETTLE(1)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_cin(cmd_cin), .cmd_tag(cmd_tag),
    .alu_opcode(alu_opcode), .alu_input1(alu_input1), .alu_input2(alu_input2),
    .alu_cin(alu_cin), .alu_result(alu_result), .alu_remainder(alu_remainder),
    .alu_overflow(alu_overflow), .alu_zero(alu_zero), .alu_sign(alu_sign),
    .alu_carry(alu_carry), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_remainder(rsp_remainder), .rsp_flags(rsp_flags),
    .rsp_err(rsp_err), .rsp_tag(rsp_tag), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] r;
    logic [31:0] rem;
    logic [3:0]  fl;
  } alu_out_t;

  typedef struct packed {
    logic [31:0] r;
    logic [31:0] rem;
    logic [3:0]  fl;
    logic        err;
    logic [3:0]  tag;
  } exp_t;

  int   total = 0;
  int   bad = 0;
  int   n_acc = 0;
  int   n_rsp = 0;
  int   n_drop = 0;
  bit   done = 1'b0;
  exp_t exp_q[$];

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Opcode map of the attached ALU; non-divide ops drive a junk remainder
  function automatic alu_out_t alu_fn(input logic [15:0] op, input logic [31:0] a,
                                      input logic [31:0] b, input logic cin);
    alu_out_t o;
    logic [32:0] s;
    logic v, c;
    v = 1'b0; c = 1'b0; s = '0;
    o.rem = 32'hDEAD_BEEF;
    case (op)
      16'd0: begin
        s = {1'b0, a} + {1'b0, b} + {32'd0, cin};
        o.r = s[31:0]; c = s[32];
        v = (a[31] == b[31]) && (o.r[31] != a[31]);
      end
      16'd1: begin
        s = {1'b0, a} - {1'b0, b};
        o.r = s[31:0]; c = s[32];
        v = (a[31] != b[31]) && (o.r[31] != a[31]);
      end
      16'd2: begin
        o.r   = (b != 0) ? a / b : 32'd0;
        o.rem = (b != 0) ? a % b : 32'd0;
      end
      16'd3:  o.r = a & b;
      16'd4:  o.r = a | b;
      16'd5:  o.r = a ^ b;
      16'd6:  o.r = ~(a | b);
      16'd7:  o.r = a << b[4:0];
      16'd8:  o.r = a >> b[4:0];
      16'd9:  o.r = a * b;
      16'd10: o.r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      16'd11: o.r = a;
      16'd12: o.r = b;
      16'd13: o.r = ~(a & b);
      default: o.r = 32'd0;
    endcase
    o.fl = {v, (o.r == 32'd0), o.r[31], c};
    return o;
  endfunction

  function automatic exp_t predict(input logic [15:0] op, input logic [31:0] a,
                                   input logic [31:0] b, input logic cin, input logic [3:0] tg);
    exp_t e;
    alu_out_t o;
    e.tag = tg;
    if (op > 16'd13) begin
      e.r = 32'd0; e.rem = 32'd0; e.fl = 4'd0; e.err = 1'b1;
    end else if (op == 16'd2 && b == 32'd0) begin
      e.r = 32'hFFFF_FFFF; e.rem = a; e.fl = 4'd0; e.err = 1'b1;
    end else begin
      o = alu_fn(op, a, b, cin);
      e.r = o.r; e.rem = (op == 16'd2) ? o.rem : 32'd0; e.fl = o.fl; e.err = 1'b0;
    end
    return e;
  endfunction

  alu_out_t ao;
  always_comb ao = alu_fn(alu_opcode, alu_input1, alu_input2, alu_cin);
  assign alu_result    = ao.r;
  assign alu_remainder = ao.rem;
  assign {alu_overflow, alu_zero, alu_sign, alu_carry} = ao.fl;

  // Scoreboard: sampled at negedge, between input changes and the next active edge
  bit   stalled = 1'b0;
  exp_t saved, cur, e;
  always @(negedge clk) begin
    cur = '{r: rsp_result, rem: rsp_remainder, fl: rsp_flags, err: rsp_err, tag: rsp_tag};
    if (reset) begin
      n_drop += exp_q.size();
      exp_q.delete();
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        check("stall_valid", 96'(rsp_valid), 96'(1'b1));
        check("stall_data", 96'(cur), 96'(saved));
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          check("extra_rsp", 96'(1'b1), 96'(1'b0));
        end else begin
          e = exp_q.pop_front();
          check("rsp_result", 96'(rsp_result), 96'(e.r));
          check("rsp_remainder", 96'(rsp_remainder), 96'(e.rem));
          check("rsp_flags_err_tag", 96'({rsp_flags, rsp_err, rsp_tag}), 96'({e.fl, e.err, e.tag}));
        end
        n_rsp++;
      end
      stalled = rsp_valid && !rsp_ready;
      saved   = cur;
      if (cmd_valid && cmd_ready) begin
        exp_q.push_back(predict(cmd_opcode, cmd_a, cmd_b, cmd_cin, cmd_tag));
        n_acc++;
      end
    end
  end

  // Entered and left at posedge+1; ok reports whether the command was accepted
  task automatic push_cmd(input logic [15:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic cin, input logic [3:0] tg, input int max_wait,
                          output bit ok);
    cmd_valid = 1'b1; cmd_opcode = op; cmd_a = a; cmd_b = b; cmd_cin = cin; cmd_tag = tg;
    ok = 1'b0;
    for (int i = 0; i < max_wait && !ok; i++) begin
      @(negedge clk);
      if (cmd_ready) ok = 1'b1;
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
  endtask

  // Leaves at the negedge where rsp_valid is seen high
  task automatic wait_rsp(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    check(tag, 96'(seen), 96'(1'b1));
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    bit ok;
    int base;
    logic [15:0] op;
    logic [31:0] a, b;

    reset = 1'b1; cmd_valid = 1'b0; cmd_opcode = '0; cmd_a = '0; cmd_b = '0;
    cmd_cin = 1'b0; cmd_tag = '0; rsp_ready = 1'b1;
    idle_cycles(2);
    check("rst_valid", 96'(rsp_valid), 96'(1'b0));
    check("rst_count", 96'(count), 96'(0));
    check("rst_ready_low", 96'(cmd_ready), 96'(1'b0));
    check("rst_alu", 96'({alu_opcode, alu_input1, alu_cin}), 96'(0));
    reset = 1'b0;
    #1;
    check("ready_after_rst", 96'(cmd_ready), 96'(1'b1));
    @(posedge clk); #1;

    // ADD 5+7: alu pins loaded one edge after acceptance, response one edge later
    push_cmd(16'd0, 32'd5, 32'd7, 1'b0, 4'd3, 10, ok);
    check("add_accept", 96'(ok), 96'(1'b1));
    @(posedge clk); #1;
    check("add_drive_in1", 96'(alu_input1), 96'(5));
    check("add_drive_noval", 96'(rsp_valid), 96'(1'b0));
    @(posedge clk); #1;
    check("add_valid", 96'(rsp_valid), 96'(1'b1));
    check("add_result", 96'(rsp_result), 96'(12));
    check("add_zero", 96'(rsp_flags[2]), 96'(1'b0));
    check("add_err_tag", 96'({rsp_err, rsp_tag}), 96'({1'b0, 4'd3}));
    idle_cycles(2);

    push_cmd(16'd2, 32'd100, 32'd7, 1'b0, 4'd4, 10, ok);
    wait_rsp("div_wait");
    check("div_result", 96'(rsp_result), 96'(14));
    check("div_rem", 96'(rsp_remainder), 96'(2));
    @(posedge clk); #1;

    push_cmd(16'd2, 32'd9, 32'd0, 1'b0, 4'd5, 10, ok);
    @(posedge clk); #1;
    check("div0_valid", 96'(rsp_valid), 96'(1'b1));
    check("div0_result", 96'(rsp_result), 96'(32'hFFFF_FFFF));
    check("div0_rem", 96'(rsp_remainder), 96'(9));
    check("div0_err", 96'(rsp_err), 96'(1'b1));
    check("div0_no_drive", 96'({alu_opcode, alu_input1}), 96'({16'd2, 32'd100}));
    idle_cycles(2);

    push_cmd(16'd20, 32'd1, 32'd1, 1'b0, 4'd6, 10, ok);
    @(posedge clk); #1;
    check("ill_valid", 96'(rsp_valid), 96'(1'b1));
    check("ill_result_err", 96'({rsp_result, rsp_err}), 96'({32'd0, 1'b1}));
    push_cmd(16'd1, 32'd10, 32'd4, 1'b0, 4'd7, 10, ok);
    wait_rsp("sub_wait");
    check("sub_result_err", 96'({rsp_result, rsp_err}), 96'({32'd6, 1'b0}));
    @(posedge clk); #1;
    idle_cycles(2);

    // Backpressure: one command sits in HOLD while four fill the FIFO
    rsp_ready = 1'b0;
    base = n_rsp;
    for (int i = 0; i < 5; i++) begin
      push_cmd(16'd0, 32'(i), 32'(i), 1'b0, 4'(i), 5, ok);
      check("fill_accept", 96'(ok), 96'(1'b1));
    end
    check("full_count", 96'(count), 96'(4));
    check("full_ready", 96'(cmd_ready), 96'(1'b0));
    push_cmd(16'd0, 32'd9, 32'd9, 1'b0, 4'd9, 3, ok);
    check("full_reject", 96'(ok), 96'(1'b0));
    rsp_ready = 1'b1;
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) idle_cycles(1);
    check("fill_rsp_count", 96'(n_rsp - base), 96'(5));
    idle_cycles(2);

    // Reset mid-DRIVE with two commands still queued
    rsp_ready = 1'b0;
    push_cmd(16'd15, 32'd0, 32'd0, 1'b0, 4'd5, 5, ok);
    push_cmd(16'd0, 32'h11, 32'd1, 1'b0, 4'd6, 5, ok);
    push_cmd(16'd0, 32'd2, 32'd2, 1'b0, 4'd7, 5, ok);
    push_cmd(16'd0, 32'd3, 32'd3, 1'b0, 4'd8, 5, ok);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check("pre_rst_count", 96'(count), 96'(2));
    check("pre_rst_drive", 96'(alu_input1), 96'(32'h11));
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    rsp_ready = 1'b1;
    #1;
    check("post_rst_valid", 96'(rsp_valid), 96'(1'b0));
    check("post_rst_count", 96'(count), 96'(0));
    check("post_rst_ready", 96'(cmd_ready), 96'(1'b1));
    check("post_rst_alu", 96'(alu_input1), 96'(0));
    @(posedge clk); #1;
    push_cmd(16'd5, 32'hF0F0, 32'h0FF0, 1'b0, 4'd1, 10, ok);
    wait_rsp("xor_wait");
    check("xor_result", 96'(rsp_result), 96'(32'hFF00));
    @(posedge clk); #1;

    // Randomized commands with random downstream stalls
    fork
      begin
        for (int n = 0; n < 200; n++) begin
          if ($urandom_range(0, 9) == 0) op = 16'($urandom_range(14, 65535));
          else                           op = 16'($urandom_range(0, 13));
          a = $urandom;
          b = $urandom;
          if (op == 16'd2) b = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom_range(1, 1000));
          push_cmd(op, a, b, 1'($urandom_range(0, 1)), 4'(n), 2000, ok);
          check("rand_accept", 96'(ok), 96'(1'b1));
          repeat ($urandom_range(0, 2)) idle_cycles(1);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          rsp_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    rsp_ready = 1'b1;
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) idle_cycles(1);
    check("drain_empty", 96'(exp_q.size()), 96'(0));
    check("rsp_accounting", 96'(n_rsp + n_drop), 96'(n_acc));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
